// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs field-level requests into 32-bit words and queues them in a FIFO.
// Optional immediate range checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fmt,
    input  logic [6:0]      in_opcode,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_err,
    output logic [15:0]     enc_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = 32;
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [IW-1:0] NOP_WORD = 32'h0000_0013;

    // FIFO storage and control state
    logic [IW-1:0] r_mem_instr [DEPTH];
    logic          r_mem_err   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [IW-1:0] r_out_instr;
    logic          r_out_err;
    logic [15:0]   r_enc_count;

    logic [IW-1:0] w_word;
    logic          w_err;
    logic          w_hs;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_cnt_after_pop;
    logic [CW-1:0] w_next_count;
    logic [AW-1:0] w_next_rd;
    logic [AW-1:0] w_next_wr;
    logic          w_unused_imm;

    assign w_unused_imm = ^in_imm;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // Immediate fits a signed N-bit field when everything above bit N-2 is a pure sign copy
    logic [XLEN-1:0] w_sh11;
    logic [XLEN-1:0] w_sh12;
    logic [XLEN-1:0] w_sh20;
    logic [XLEN-1:0] w_sh31;
    logic            w_fit12;
    logic            w_fit13;
    logic            w_fit21;
    logic            w_fit32;

    assign w_sh11  = XLEN'($signed(in_imm) >>> 11);
    assign w_sh12  = XLEN'($signed(in_imm) >>> 12);
    assign w_sh20  = XLEN'($signed(in_imm) >>> 20);
    assign w_sh31  = XLEN'($signed(in_imm) >>> 31);
    assign w_fit12 = (&w_sh11) | ~(|w_sh11);
    assign w_fit13 = (&w_sh12) | ~(|w_sh12);
    assign w_fit21 = (&w_sh20) | ~(|w_sh20);
    assign w_fit32 = (&w_sh31) | ~(|w_sh31);
`endif

    // Field packing for the current request
    always_comb begin
        w_word = NOP_WORD;
        w_err  = 1'b0;
        case (in_fmt)
            FMT_R: begin
                w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_I: begin
                w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                w_err  = !w_fit12;
`endif
            end
            FMT_S: begin
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                w_err  = !w_fit12;
`endif
            end
            FMT_B: begin
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                w_err  = !w_fit13 || in_imm[0];
`endif
            end
            FMT_U: begin
                w_word = {in_imm[31:12], in_rd, in_opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                w_err  = (in_imm[11:0] != 12'd0) || !w_fit32;
`endif
            end
            FMT_J: begin
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                w_err  = !w_fit21 || in_imm[0];
`endif
            end
            default: begin
                w_word = NOP_WORD;
                w_err  = 1'b1;
            end
        endcase
    end

    // Handshakes: a flush drops the push but the handshake still counts
    assign w_hs            = in_valid && r_in_ready;
    assign w_push          = w_hs && !flush;
    assign w_pop           = r_out_valid && out_ready && !flush;
    assign w_cnt_after_pop = r_count - CW'(w_pop);

    always_comb begin
        w_next_count = w_cnt_after_pop + CW'(w_push);
        w_next_rd    = w_pop  ? AW'(r_rd_ptr + 1'b1) : r_rd_ptr;
        w_next_wr    = w_push ? AW'(r_wr_ptr + 1'b1) : r_wr_ptr;
        if (flush) begin
            w_next_count = '0;
            w_next_rd    = '0;
            w_next_wr    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= w_word;
            r_mem_err[r_wr_ptr]   <= w_err;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= 1'b0;
            r_enc_count <= '0;
        end else begin
            r_wr_ptr    <= w_next_wr;
            r_rd_ptr    <= w_next_rd;
            r_count     <= w_next_count;
            r_in_ready  <= (w_next_count != CW'(DEPTH));
            r_out_valid <= (w_next_count != '0);
            if (w_hs) begin
                r_enc_count <= r_enc_count + 16'd1;
            end
            // Head register: bypass the new word into an otherwise empty queue, else read memory
            if (w_push && (w_cnt_after_pop == '0)) begin
                r_out_instr <= w_word;
                r_out_err   <= w_err;
            end else if (w_next_count != '0) begin
                r_out_instr <= r_mem_instr[w_next_rd];
                r_out_err   <= r_mem_err[w_next_rd];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign enc_count = r_enc_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encoding, FIFO full/pop, flush, range flags, reset.
module tb_instr_encoder;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_fmt;
    logic [6:0]      in_opcode;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic [XLEN-1:0] in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic            out_err;
    logic [15:0]     enc_count;

    int total;
    int bad;

    instr_encoder #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [XLEN-1:0] imm);
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, '0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h exp=00000000", out_instr); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        total++; if (enc_count !== 16'd0) begin bad++; $display("FAIL reset_enc_count got=%0d exp=0", enc_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_addi();
        @(negedge clk);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(5));
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        total++; if (out_instr !== 32'h0050_0093) begin bad++; $display("FAIL addi_word got=%h exp=00500093", out_instr); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL addi_err got=%b exp=0", out_err); end
        total++; if (enc_count !== 16'd1) begin bad++; $display("FAIL addi_count got=%0d exp=1", enc_count); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_empty got=%b exp=0", out_valid); end
        total++; if (out_instr !== 32'h0050_0093) begin bad++; $display("FAIL addi_hold got=%h exp=00500093", out_instr); end
    endtask

    task automatic test_branch_jal();
        @(negedge clk);
        set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, XLEN'(-4));
        @(negedge clk);
        set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(2048));
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_instr !== 32'hFE20_8EE3) begin bad++; $display("FAIL beq_word got=%h exp=FE208EE3", out_instr); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL beq_err got=%b exp=0", out_err); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL jal_valid got=%b exp=1", out_valid); end
        total++; if (out_instr !== 32'h0010_00EF) begin bad++; $display("FAIL jal_word got=%h exp=001000EF", out_instr); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (enc_count !== 16'd3) begin bad++; $display("FAIL bj_count got=%0d exp=3", enc_count); end
    endtask

    task automatic test_full_and_pop();
        logic [31:0] exp_w [DEPTH];
        exp_w[0] = 32'h0010_0093;
        exp_w[1] = 32'h0020_0093;
        exp_w[2] = 32'h0030_0093;
        exp_w[3] = 32'h0040_0093;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(k + 1));
        end
        @(negedge clk);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(DEPTH + 1));
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_hold_ready got=%b exp=0", in_ready); end
        total++; if (enc_count !== 16'd7) begin bad++; $display("FAIL full_count got=%0d exp=7", enc_count); end
        total++; if (out_instr !== exp_w[0]) begin bad++; $display("FAIL full_head got=%h exp=%h", out_instr, exp_w[0]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pop_ready got=%b exp=1", in_ready); end
        total++; if (enc_count !== 16'd7) begin bad++; $display("FAIL pop_count got=%0d exp=7", enc_count); end
        for (int k = 1; k < DEPTH; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid idx=%0d got=%b exp=1", k, out_valid); end
            total++; if (out_instr !== exp_w[k]) begin bad++; $display("FAIL drain_word idx=%0d got=%h exp=%h", k, out_instr, exp_w[k]); end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(1));
        @(negedge clk);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(2));
        @(negedge clk);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(3));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++; if (enc_count !== 16'd10) begin bad++; $display("FAIL flush_count got=%0d exp=10", enc_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(negedge clk);
        set_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, '0);
        @(negedge clk);
        set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, XLEN'(8));
        total++; if (out_instr !== 32'h0020_81B3) begin bad++; $display("FAIL b2b_add got=%h exp=002081B3", out_instr); end
        @(negedge clk);
        set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(32'h1234_5000));
        total++; if (out_instr !== 32'h0020_A423) begin bad++; $display("FAIL b2b_sw got=%h exp=0020A423", out_instr); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_instr !== 32'h1234_52B7) begin bad++; $display("FAIL b2b_lui got=%h exp=123452B7", out_instr); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
        total++; if (out_instr !== 32'h1234_52B7) begin bad++; $display("FAIL b2b_hold got=%h exp=123452B7", out_instr); end
    endtask

    task automatic test_range();
        logic exp_rng;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        exp_rng = 1'b1;
`else
        exp_rng = 1'b0;
`endif
        @(negedge clk);
        set_req(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(2048));
        @(negedge clk);
        set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(3));
        @(negedge clk);
        set_req(3'd6, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, XLEN'(99));
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_instr !== 32'h8000_0013) begin bad++; $display("FAIL rng_i_word got=%h exp=80000013", out_instr); end
        total++; if (out_err !== exp_rng) begin bad++; $display("FAIL rng_i_err got=%b exp=%b", out_err, exp_rng); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_instr !== 32'h0000_0163) begin bad++; $display("FAIL rng_b_word got=%h exp=00000163", out_instr); end
        total++; if (out_err !== exp_rng) begin bad++; $display("FAIL rng_b_err got=%b exp=%b", out_err, exp_rng); end
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_instr !== 32'h0000_0013) begin bad++; $display("FAIL rsv_word got=%h exp=00000013", out_instr); end
        total++; if (out_err !== 1'b1) begin bad++; $display("FAIL rsv_err got=%b exp=1", out_err); end
        total++; if (enc_count !== 16'd16) begin bad++; $display("FAIL rng_count got=%0d exp=16", enc_count); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, XLEN'(5));
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        total++; if (enc_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", enc_count); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_mid_instr got=%h exp=00000000", out_instr); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_after got=%b exp=0", out_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_addi();
        test_branch_jal();
        test_full_and_pop();
        test_flush();
        test_back_to_back();
        test_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
